// File: rtl/alu_ctrl_pkg.sv
// ALU control package for the LEGv8 ID/EX boundary.
// Opcode/ALU-code constants and the combinational decode table.
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_LDST  = 2'b00;
  localparam logic [1:0] ALUOP_CBZ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;
  localparam logic [10:0] OPC_MUL = 11'b10011011000;
  localparam logic [10:0] OPC_DIV = 11'b10011010110;
  localparam logic [10:0] OPC_LSL = 11'b11010011011;
  localparam logic [10:0] OPC_LSR = 11'b11010011010;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_MUL   = 4'b0011;
  localparam logic [3:0] ALU_DIV   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_LSL   = 4'b1000;
  localparam logic [3:0] ALU_LSR   = 4'b1001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mc_state_e;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       mc;
    logic       illegal;
  } dec_t;

  // alu_op[0] wins over alu_op[1]; unknown R-type opcodes
  // decode to AND with the illegal flag raised.
  function automatic dec_t decode_alu(
    input logic [1:0]  alu_op,
    input logic [10:0] opcode
  );
    dec_t d;
    d.ctrl    = ALU_AND;
    d.mc      = 1'b0;
    d.illegal = 1'b0;
    if (alu_op[0]) begin
      d.ctrl = ALU_PASSB;
    end else if (!alu_op[1]) begin
      d.ctrl = ALU_ADD;
    end else begin
      unique case (opcode)
        OPC_ADD: d.ctrl = ALU_ADD;
        OPC_SUB: d.ctrl = ALU_SUB;
        OPC_AND: d.ctrl = ALU_AND;
        OPC_ORR: d.ctrl = ALU_ORR;
        OPC_MUL: begin
          d.ctrl = ALU_MUL;
          d.mc   = 1'b1;
        end
        OPC_DIV: begin
          d.ctrl = ALU_DIV;
          d.mc   = 1'b1;
        end
        OPC_LSL: d.ctrl = ALU_LSL;
        OPC_LSR: d.ctrl = ALU_LSR;
        default: d.illegal = 1'b1;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_pipe_timer.sv
// Multi-cycle op countdown timer.
// 4-bit load/decrement counter with a zero flag.
import alu_ctrl_pkg::*;

module alu_mc_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic       dec_i,
  input  logic [3:0] load_val_i,
  output logic [3:0] cnt_o,
  output logic       zero_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Clear beats load, load beats decrement; never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 4'd0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control generator at the ID/EX boundary.
// Decodes ALUOp/opcode and sequences multi-cycle MUL/DIV.
import alu_ctrl_pkg::*;

module alu_ctrl_pipe #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter bit EN_MC   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [1:0]  alu_op,
  input  logic [10:0] opcode,
  input  logic        stall_in,
  input  logic        flush,
  output logic        in_ready,
  output logic        valid_out,
  output logic [3:0]  alu_ctrl,
  output logic        illegal,
  output logic        mc_start,
  output logic        mc_done,
  output logic        stall_req
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

  mc_state_e state_q, state_d;
  logic      done_q, done_d;
  logic      valid_q;
  logic [3:0] ctrl_q;
  logic      ill_q;
  logic      start_q;

  dec_t dec;
  dec_t dec_m;

  logic       load;
  logic       accept;
  logic       start;
  logic       tmr_clr;
  logic       tmr_load;
  logic       tmr_dec;
  logic [3:0] tmr_val;
  logic [3:0] cnt;
  logic       zero;

  // Raw decode, then demote MUL/DIV to illegal when
  // multi-cycle support is compiled out.
  always_comb begin
    dec   = decode_alu(alu_op, opcode);
    dec_m = dec;
    if (dec.mc && !EN_MC) begin
      dec_m.ctrl    = ALU_AND;
      dec_m.mc      = 1'b0;
      dec_m.illegal = 1'b1;
    end
  end

  assign stall_req = (state_q == ST_RUN) && !zero;
  assign in_ready  = !reset && !stall_req && !stall_in;
  assign mc_done   = (state_q == ST_RUN) && zero && !done_q;

  assign load   = in_ready && !flush;
  assign accept = load && valid_in;
  assign start  = accept && dec_m.mc;

  assign tmr_val = (dec_m.ctrl == ALU_DIV) ? DIV_CNT : MUL_CNT;

  // IDLE/RUN next state; done_q remembers a mc_done already
  // shown while stall_in keeps us parked at cnt==0.
  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      tmr_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d  = ST_RUN;
            done_d   = 1'b0;
            tmr_load = 1'b1;
          end
        end
        ST_RUN: begin
          if (!zero) begin
            tmr_dec = 1'b1;
          end else if (stall_in) begin
            done_d = 1'b1;
          end else if (start) begin
            state_d  = ST_RUN;
            done_d   = 1'b0;
            tmr_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
          end
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // EX output register: loads on every accept slot, holds otherwise.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= 4'd0;
      ill_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= start;
      if (load) begin
        valid_q <= valid_in;
        ctrl_q  <= valid_in ? dec_m.ctrl : 4'd0;
        ill_q   <= valid_in && dec_m.illegal;
      end
    end
  end

  alu_mc_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .dec_i      (tmr_dec),
    .load_val_i (tmr_val),
    .cnt_o      (cnt),
    .zero_o     (zero)
  );

  assign valid_out = valid_q;
  assign alu_ctrl  = ctrl_q;
  assign illegal   = ill_q;
  assign mc_start  = start_q;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Bench for alu_ctrl_pipe: directed steps then random traffic,
// every cycle checked against a behavioural model.
module tb_alu_ctrl_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [1:0]  alu_op;
  logic [10:0] opcode;
  logic        stall_in;
  logic        flush;
  logic        in_ready, valid_out, illegal, mc_start, mc_done, stall_req;
  logic [3:0]  alu_ctrl;
  logic        in_ready1, valid_out1, illegal1, mc_start1, mc_done1, stall_req1;
  logic [3:0]  alu_ctrl1;

  always #5 clk = ~clk;

  alu_ctrl_pipe #(.MUL_LAT(3), .DIV_LAT(8), .EN_MC(1'b1)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .alu_op(alu_op),
    .opcode(opcode), .stall_in(stall_in), .flush(flush),
    .in_ready(in_ready), .valid_out(valid_out), .alu_ctrl(alu_ctrl),
    .illegal(illegal), .mc_start(mc_start), .mc_done(mc_done),
    .stall_req(stall_req)
  );

  alu_ctrl_pipe #(.MUL_LAT(3), .DIV_LAT(8), .EN_MC(1'b0)) dut_nomc (
    .clk(clk), .reset(reset), .valid_in(valid_in), .alu_op(alu_op),
    .opcode(opcode), .stall_in(stall_in), .flush(flush),
    .in_ready(in_ready1), .valid_out(valid_out1), .alu_ctrl(alu_ctrl1),
    .illegal(illegal1), .mc_start(mc_start1), .mc_done(mc_done1),
    .stall_req(stall_req1)
  );

  localparam logic [10:0] T_OPC [8] = '{
    11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
    11'b10011011000, 11'b10011010110, 11'b11010011011, 11'b11010011010
  };
  localparam logic [3:0] T_ALU [8] = '{
    4'b0010, 4'b0110, 4'b0000, 4'b0001,
    4'b0011, 4'b0100, 4'b1000, 4'b1001
  };
  localparam int T_LAT [8] = '{0, 0, 0, 0, 3, 8, 0, 0};

  int n_cmp = 0;
  int n_err = 0;
  int done_seen_cnt = 0;

  // Model: held op plus "age" of the multi-cycle op in cycles since it entered EX.
  logic       m_valid, m_ill, m_start, m_busy, m_done_shown;
  logic [3:0] m_ctrl;
  int         m_age, m_lat;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_dec(input logic [1:0] op, input logic [10:0] opc,
                         output logic [3:0] c, output logic ill, output int lat);
    c = 4'b0000; ill = 1'b0; lat = 0;
    if (op[0]) c = 4'b0111;
    else if (op == 2'b00) c = 4'b0010;
    else begin
      ill = 1'b1;
      for (int i = 0; i < 8; i++)
        if (opc == T_OPC[i]) begin
          c = T_ALU[i]; ill = 1'b0; lat = T_LAT[i];
        end
    end
  endtask

  function automatic logic e_stall();
    return m_busy && (m_age < m_lat);
  endfunction

  function automatic logic e_done();
    return m_busy && (m_age >= m_lat) && !m_done_shown;
  endfunction

  function automatic logic e_ready();
    return !reset && !e_stall() && !stall_in;
  endfunction

  task automatic check_all();
    chk("valid_out", {3'b0, valid_out}, {3'b0, m_valid});
    chk("alu_ctrl", alu_ctrl, m_ctrl);
    chk("illegal", {3'b0, illegal}, {3'b0, m_ill});
    chk("mc_start", {3'b0, mc_start}, {3'b0, m_start});
    chk("mc_done", {3'b0, mc_done}, {3'b0, e_done()});
    chk("stall_req", {3'b0, stall_req}, {3'b0, e_stall()});
    chk("in_ready", {3'b0, in_ready}, {3'b0, e_ready()});
    if (mc_done === 1'b1) done_seen_cnt++;
  endtask

  task automatic model_edge();
    logic       acc, d;
    logic [3:0] c;
    logic       il;
    int         lat;
    acc = e_ready();
    d   = e_done();
    if (reset || flush) begin
      m_valid = 0; m_ctrl = 0; m_ill = 0; m_start = 0;
      m_busy = 0; m_age = 0; m_lat = 0; m_done_shown = 0;
    end else begin
      m_start = 0;
      if (m_busy) begin
        if (m_age < m_lat) m_age++;
        else begin
          if (d) m_done_shown = 1;
          if (!stall_in) m_busy = 0;
        end
      end
      if (acc) begin
        ref_dec(alu_op, opcode, c, il, lat);
        m_valid = valid_in;
        m_ctrl  = valid_in ? c : 4'd0;
        m_ill   = valid_in && il;
        if (valid_in && lat != 0) begin
          m_busy = 1; m_age = 1; m_lat = lat;
          m_done_shown = 0; m_start = 1;
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic [1:0] op, input logic [10:0] opc,
                      input logic st, input logic fl, input logic rs);
    valid_in = v; alu_op = op; opcode = opc;
    stall_in = st; flush = fl; reset = rs;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b10, 11'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [10:0] ro;
    int k;
    m_valid = 0; m_ctrl = 0; m_ill = 0; m_start = 0;
    m_busy = 0; m_age = 0; m_lat = 0; m_done_shown = 0;
    valid_in = 1; alu_op = 2'b10; opcode = T_OPC[0];
    stall_in = 0; flush = 0; reset = 1;
    @(posedge clk); #1;

    step(1'b1, 2'b10, T_OPC[4], 1'b0, 1'b0, 1'b1);
    step(1'b1, 2'b10, T_OPC[4], 1'b0, 1'b0, 1'b1);
    chk("rst_valid", {3'b0, valid_out}, 4'd0);
    chk("rst_ctrl", alu_ctrl, 4'd0);
    chk("rst_start", {3'b0, mc_start}, 4'd0);

    for (int i = 0; i < 8; i++)
      if (T_LAT[i] == 0) step(1'b1, 2'b10, T_OPC[i], 1'b0, 1'b0, 1'b0);
    idle(1);

    step(1'b1, 2'b10, T_OPC[4], 1'b0, 1'b0, 1'b0);
    chk("nomc_ill", {3'b0, illegal1}, 4'd1);
    chk("nomc_ctrl", alu_ctrl1, 4'd0);
    chk("nomc_start", {3'b0, mc_start1}, 4'd0);
    chk("mul_start", {3'b0, mc_start}, 4'd1);
    idle(2);
    chk("mul_done", {3'b0, mc_done}, 4'd1);
    step(1'b1, 2'b10, T_OPC[0], 1'b0, 1'b0, 1'b0);
    chk("after_mul", alu_ctrl, 4'b0010);
    idle(1);

    step(1'b1, 2'b10, 11'b11111111111, 1'b0, 1'b0, 1'b0);
    chk("ill_flag", {3'b0, illegal}, 4'd1);
    step(1'b1, 2'b01, 11'($urandom), 1'b0, 1'b0, 1'b0);
    chk("cbz_ctrl", alu_ctrl, 4'b0111);
    idle(1);

    for (int r = 0; r < 2; r++) begin
      done_seen_cnt = 0;
      step(1'b1, 2'b10, T_OPC[5], 1'b0, 1'b0, 1'b0);
      idle(3);
      step(1'b1, 2'b10, T_OPC[0], 1'b0, r == 0, r == 1);
      chk("kill_valid", {3'b0, valid_out}, 4'd0);
      chk("kill_stall", {3'b0, stall_req}, 4'd0);
      idle(6);
      chk("kill_nodone", done_seen_cnt[3:0], 4'd0);
    end

    done_seen_cnt = 0;
    step(1'b1, 2'b10, T_OPC[4], 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 2'b10, T_OPC[1], 1'b1, 1'b0, 1'b0);
      chk("stall_hold", alu_ctrl, 4'b0011);
    end
    idle(2);
    chk("stall_one_done", done_seen_cnt[3:0], 4'd1);

    for (int i = 0; i < 400; i++) begin
      k  = $urandom_range(0, 9);
      ro = (k < 8) ? T_OPC[k] : 11'($urandom);
      step(($urandom % 4) != 0, 2'($urandom_range(0, 5) < 4 ? 2 : $urandom),
           ro, ($urandom % 7) == 0, ($urandom % 25) == 0, ($urandom % 50) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
